// File: rtl/touch_led_ctrl.sv
// Touch-key LED controller: short presses step OFF/ON/SLOW/FAST, a long press forces OFF.
// Optional debounce filter is built only when TOUCH_LED_DEBOUNCE_EN is defined.
module touch_led_ctrl #(
    parameter int DEB_CYC   = 1000000,
    parameter int LONG_CYC  = 50000000,
    parameter int SLOW_HALF = 25000000,
    parameter int FAST_HALF = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       touch_key,
    output logic       led,
    output logic [1:0] mode,
    output logic       key_evt
);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_t;

    localparam int HOLD_W    = $clog2(LONG_CYC + 1);
    localparam int BLINK_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int BLINK_W   = $clog2(BLINK_MAX + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(LONG_CYC);
    localparam logic [BLINK_W-1:0] SLOW_LAST = BLINK_W'(SLOW_HALF - 1);
    localparam logic [BLINK_W-1:0] FAST_LAST = BLINK_W'(FAST_HALF - 1);

    if (DEB_CYC < 1 || LONG_CYC < 1 || SLOW_HALF < 1 || FAST_HALF < 1) begin : g_param_check
        $error("touch_led_ctrl: cycle parameters must be 1 or more");
    end

    logic [1:0]         r_sync;
    logic               w_key_db;
    logic               r_key_db_d;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_long_fired;
    logic [BLINK_W-1:0] r_blink_cnt;
    mode_t              r_mode;
    mode_t              w_mode_nxt;
    logic               r_led;
    logic               r_key_evt;
    logic               w_rise;
    logic               w_fall;
    logic               w_long;
    logic               w_short;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], touch_key};
        end
    end

`ifdef TOUCH_LED_DEBOUNCE_EN
    localparam int                DEB_W    = $clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYC - 1);

    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_key_db;

    // The level is accepted on the DEB_CYC-th consecutive differing cycle; agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_cnt <= '0;
            r_key_db  <= 1'b0;
        end else if (r_sync[1] == r_key_db) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_deb_cnt <= '0;
            r_key_db  <= r_sync[1];
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_key_db = r_key_db;
`else
    assign w_key_db = r_sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_db_d <= 1'b0;
        end else begin
            r_key_db_d <= w_key_db;
        end
    end

    assign w_rise  = w_key_db & ~r_key_db_d;
    assign w_fall  = ~w_key_db & r_key_db_d;
    assign w_long  = w_key_db & ~w_rise & ~r_long_fired & (r_hold_cnt == HOLD_LAST);
    assign w_short = w_fall & ~r_long_fired;

    // Hold counter saturates, so a single press can cross HOLD_LAST only once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt   <= '0;
            r_long_fired <= 1'b0;
        end else if (w_rise) begin
            r_hold_cnt   <= '0;
            r_long_fired <= 1'b0;
        end else if (w_key_db) begin
            if (r_hold_cnt != HOLD_MAX) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            if (w_long) begin
                r_long_fired <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= MODE_OFF;
            r_key_evt <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_key_evt <= w_short;
        end
    end

    always_comb begin
        // NOTE: the default assignment first keeps this block free of inferred latches.
        w_mode_nxt = r_mode;
        if (w_long) begin
            w_mode_nxt = MODE_OFF;
        end else if (w_short) begin
            case (r_mode)
                MODE_OFF:  w_mode_nxt = MODE_ON;
                MODE_ON:   w_mode_nxt = MODE_SLOW;
                MODE_SLOW: w_mode_nxt = MODE_FAST;
                MODE_FAST: w_mode_nxt = MODE_OFF;
                default:   w_mode_nxt = MODE_OFF;
            endcase
        end
    end

    // A mode change restarts the blink phase lit, on the same edge the mode register updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led       <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_mode_nxt != r_mode) begin
            r_led       <= (w_mode_nxt != MODE_OFF);
            r_blink_cnt <= '0;
        end else begin
            case (r_mode)
                MODE_OFF: begin
                    r_led       <= 1'b0;
                    r_blink_cnt <= '0;
                end
                MODE_ON: begin
                    r_led       <= 1'b1;
                    r_blink_cnt <= '0;
                end
                MODE_SLOW: begin
                    if (r_blink_cnt == SLOW_LAST) begin
                        r_blink_cnt <= '0;
                        r_led       <= ~r_led;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                end
                MODE_FAST: begin
                    if (r_blink_cnt == FAST_LAST) begin
                        r_blink_cnt <= '0;
                        r_led       <= ~r_led;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                end
                default: begin
                    r_led       <= 1'b0;
                    r_blink_cnt <= '0;
                end
            endcase
        end
    end

    assign led     = r_led;
    assign mode    = r_mode;
    assign key_evt = r_key_evt;

endmodule
